// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- word-memory valid/ready bus between the arbiter and the
// memory (MEM array or a slower memory behind it).
//
// Handshake: the master raises m_valid with m_addr/m_wdata/m_wmask and keeps
// all of them stable until it samples m_ready high at a rising clk edge; that
// edge both accepts and completes the transaction, and m_rdata is sampled at
// the same edge for reads (m_wmask == 0).
//
// Signals:
//   m_valid  master->slave  transaction valid
//   m_addr   master->slave  word address (ADDR_W bits)
//   m_wdata  master->slave  write data
//   m_wmask  master->slave  byte write mask, 0 = read
//   m_rdata  slave->master  read data
//   m_ready  slave->master  transaction accepted/completed this cycle
interface mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wmask;
    logic [31:0]       m_rdata;
    logic              m_ready;

    modport master (
        output m_valid, m_addr, m_wdata, m_wmask,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wmask,
        output m_rdata, m_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- round-robin arbiter sharing one word memory between the
// instruction-fetch port (i_*) and the load/store port (d_*) of the core.
// One transaction at a time is driven onto the valid/ready memory bus; the
// winning port gets its read data and a one-cycle done pulse.
//
// Parameters:
//   ADDR_W   word-address width
//   TIMEOUT  stall cycles before abort (only with ARB_TIMEOUT_EN)
//
// Build option: define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT
// stalled cycles (done + err pulse, rdata forced to 0). Without it err is
// tied low and the arbiter waits for m_ready indefinitely.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   i_req/i_addr        fetch request (level, held until i_done)
//   i_rdata/i_done      fetched word / one-cycle completion pulse
//   d_req/d_addr/d_wdata/d_wmask  data request, d_wmask == 0 means read
//   d_rdata/d_done      load data / one-cycle completion pulse
//   mem                 memory bus (master side)
//   err                 timeout abort pulse, coincident with done
//   dbg_state           current FSM state (0 IDLE, 1 BUSY_I, 2 BUSY_D)
//
// Request handshake: a port raises x_req with its address/data and holds them
// until it sees x_done high, and must drop x_req in that same cycle. Requests
// are only looked at in IDLE, and never in a cycle where a done is high, so a
// stale request is never granted twice.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    mem_arbiter_if.master     mem,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state;
    logic   last_d;     // 1: data port was served last, so fetch wins a tie
    logic   bubble;
    logic   grant_i;
    logic   grant_d;
    logic   expire;

    // A done pulse in flight means the requester has not yet dropped its req.
    assign bubble  = i_done | d_done;
    assign grant_i = (state == IDLE) && !bubble && i_req && (!d_req || last_d);
    assign grant_d = (state == IDLE) && !bubble && d_req && (!i_req || !last_d);

    assign dbg_state = state;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Abort on the edge that would take the counter to TIMEOUT, so the done
    // pulse follows exactly TIMEOUT stalled cycles.
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tcnt;
    logic             err_q;

    assign expire = (state != IDLE) && !mem.m_ready && (tcnt == T_LAST);
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= expire;
            if (grant_i || grant_d) begin
                tcnt <= '0;
            end else if ((state != IDLE) && !mem.m_ready) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_d      <= 1'b1;
            mem.m_valid <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_wdata <= '0;
            mem.m_wmask <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state       <= BUSY_I;
                        mem.m_valid <= 1'b1;
                        mem.m_addr  <= i_addr;
                        mem.m_wdata <= '0;
                        mem.m_wmask <= '0;
                    end else if (grant_d) begin
                        state       <= BUSY_D;
                        mem.m_valid <= 1'b1;
                        mem.m_addr  <= d_addr;
                        mem.m_wdata <= d_wdata;
                        mem.m_wmask <= d_wmask;
                    end
                end
                BUSY_I: begin
                    if (mem.m_ready) begin
                        state       <= IDLE;
                        mem.m_valid <= 1'b0;
                        i_done      <= 1'b1;
                        i_rdata     <= mem.m_rdata;
                        last_d      <= 1'b0;
                    end else if (expire) begin
                        state       <= IDLE;
                        mem.m_valid <= 1'b0;
                        i_done      <= 1'b1;
                        i_rdata     <= '0;
                        last_d      <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (mem.m_ready) begin
                        state       <= IDLE;
                        mem.m_valid <= 1'b0;
                        d_done      <= 1'b1;
                        // Stores leave the last load value in place.
                        if (mem.m_wmask == 4'b0000) begin
                            d_rdata <= mem.m_rdata;
                        end
                        last_d      <= 1'b1;
                    end else if (expire) begin
                        state       <= IDLE;
                        mem.m_valid <= 1'b0;
                        d_done      <= 1'b1;
                        d_rdata     <= '0;
                        last_d      <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem.m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- bench for mem_arbiter: directed scenarios plus a
// randomized two-requester run against a transaction-level memory model.
module tb_mem_arbiter;

    localparam int ADDR_W = 8;
`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif
    localparam int STALL_N = (TB_TIMEOUT > 6) ? 5 : 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic              i_req   = 1'b0;
    logic [ADDR_W-1:0] i_addr  = '0;
    logic [31:0]       i_rdata;
    logic              i_done;
    logic              d_req   = 1'b0;
    logic [ADDR_W-1:0] d_addr  = '0;
    logic [31:0]       d_wdata = '0;
    logic [3:0]        d_wmask = '0;
    logic [31:0]       d_rdata;
    logic              d_done;
    logic              err;
    logic [1:0]        dbg_state;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem       (bus),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- memory responder ----------------
    // Manual mode: tasks drive man_ready/man_rdata. Auto mode: a memory
    // array answers with random stalls of at most two cycles.
    logic        auto_resp  = 1'b0;
    logic        auto_ready = 1'b0;
    logic        man_ready  = 1'b0;
    logic [31:0] man_rdata  = '0;
    logic        mem_init   = 1'b0;
    logic [31:0] resp_mem [0:255];
    int          streak     = 0;

    assign bus.m_ready = auto_resp ? auto_ready : man_ready;
    assign bus.m_rdata = auto_resp ? resp_mem[bus.m_addr] : man_rdata;

    function automatic logic [31:0] init_word(input int a);
        return (32'h9E3779B9 * 32'(a + 1)) ^ 32'h5A5A0F0F;
    endfunction

    always @(negedge clk) begin
        if (auto_resp) begin
            if (bus.m_valid && streak < 2 && $urandom_range(0, 2) == 0) begin
                auto_ready = 1'b0;
                streak++;
            end else begin
                auto_ready = 1'b1;
                streak = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 256; a++) resp_mem[a] = init_word(a);
        end else if (auto_resp && bus.m_valid && bus.m_ready && bus.m_wmask != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (bus.m_wmask[b]) resp_mem[bus.m_addr][8*b +: 8] = bus.m_wdata[8*b +: 8];
        end
    end

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [0:0]  exp_q [$];          // expected completing port: 0 = I, 1 = D
    logic [31:0] ref_mem [0:255];

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        man_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
        checks++; if (bus.m_addr !== 8'h00) begin failures++; $display("FAIL reset_m_addr got=%h exp=00", bus.m_addr); end
        checks++; if (bus.m_wdata !== 32'h0) begin failures++; $display("FAIL reset_m_wdata got=%h exp=0", bus.m_wdata); end
        checks++; if (bus.m_wmask !== 4'h0) begin failures++; $display("FAIL reset_m_wmask got=%h exp=0", bus.m_wmask); end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", i_rdata, d_rdata); end
        checks++; if ({i_done, d_done, err} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {i_done, d_done, err}); end
    endtask

    task automatic test_single_fetch();
        i_req = 1'b1; i_addr = 8'd5; man_ready = 1'b1; man_rdata = 32'h00108093;
        @(negedge clk);   // after grant edge
        checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== 8'd5) begin failures++; $display("FAIL fetch_grant got valid=%b addr=%h exp valid=1 addr=05", bus.m_valid, bus.m_addr); end
        checks++; if (bus.m_wmask !== 4'h0 || bus.m_wdata !== 32'h0) begin failures++; $display("FAIL fetch_bus got wmask=%h wdata=%h exp 0/0", bus.m_wmask, bus.m_wdata); end
        checks++; if (i_done !== 1'b0) begin failures++; $display("FAIL fetch_early_done got=%b exp=0", i_done); end
        @(negedge clk);   // after completion edge
        checks++; if (i_done !== 1'b1 || bus.m_valid !== 1'b0) begin failures++; $display("FAIL fetch_done got done=%b valid=%b exp 1/0", i_done, bus.m_valid); end
        checks++; if (i_rdata !== 32'h00108093) begin failures++; $display("FAIL fetch_rdata got=%h exp=00108093", i_rdata); end
        checks++; if (d_done !== 1'b0) begin failures++; $display("FAIL fetch_d_done got=%b exp=0", d_done); end
        i_req = 1'b0;
        @(negedge clk);
        checks++; if (i_done !== 1'b0 || bus.m_valid !== 1'b0) begin failures++; $display("FAIL fetch_after got done=%b valid=%b exp 0/0", i_done, bus.m_valid); end
        checks++; if (i_rdata !== 32'h00108093) begin failures++; $display("FAIL fetch_rdata_hold got=%h exp=00108093", i_rdata); end
        man_ready = 1'b0;
    endtask

    task automatic test_write_mask();
        int n;
        d_req = 1'b1; d_addr = 8'd4; d_wmask = 4'b0000; man_ready = 1'b1; man_rdata = 32'hCAFE0001;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_done && n < 10);
        checks++; if (d_done !== 1'b1) begin failures++; $display("FAIL wm_read_timeout got done=%b exp=1", d_done); end
        checks++; if (d_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL wm_read_data got=%h exp=cafe0001", d_rdata); end
        d_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011; man_ready = 1'b0; man_rdata = 32'h12345678;
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== 8'd4) begin failures++; $display("FAIL wm_grant got valid=%b addr=%h exp 1/04", bus.m_valid, bus.m_addr); end
        checks++; if (bus.m_wmask !== 4'b0011 || bus.m_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wm_bus got wmask=%h wdata=%h exp 3/deadbeef", bus.m_wmask, bus.m_wdata); end
        man_ready = 1'b1;
        @(negedge clk);
        checks++; if (d_done !== 1'b1) begin failures++; $display("FAIL wm_done got=%b exp=1", d_done); end
        checks++; if (d_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL wm_rdata_kept got=%h exp=cafe0001", d_rdata); end
        d_req = 1'b0; d_wmask = 4'b0000; man_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        d_req = 1'b1; d_addr = 8'd9; d_wdata = 32'h0BADF00D; d_wmask = 4'b1100; man_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL stall_grant got=%b exp=1", bus.m_valid); end
        for (int k = 1; k <= STALL_N; k++) begin
            @(negedge clk);
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_addr !== 8'd9 || bus.m_wmask !== 4'b1100 || d_done !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got valid=%b addr=%h wmask=%h done=%b err=%b exp 1/09/c/0/0",
                         k, bus.m_valid, bus.m_addr, bus.m_wmask, d_done, err);
            end
        end
        man_ready = 1'b1;
        @(negedge clk);   // STALL_N + 1 cycles after m_valid rose
        checks++; if (d_done !== 1'b1 || bus.m_valid !== 1'b0) begin failures++; $display("FAIL stall_done got done=%b valid=%b exp 1/0", d_done, bus.m_valid); end
        d_req = 1'b0; d_wmask = 4'b0000; man_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [0:0] order [$];
        logic [0:0] exp_port;
        int i_cnt, d_cnt, cyc;
        do_reset();
        man_ready = 1'b1; man_rdata = 32'h11110000;
        i_addr = 8'h21; d_addr = 8'h42; d_wmask = 4'b0000;
        i_req = 1'b1; d_req = 1'b1;
        i_cnt = 0; d_cnt = 0; cyc = 0;
        while (order.size() < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (bus.m_valid && (i_done || d_done)) begin
                failures++;
                $display("FAIL rr_overlap cycle=%0d got valid=1 with done exp valid=0", cyc);
            end
            if (i_done) begin order.push_back(1'b0); i_req = 1'b0; i_cnt++; end
            else if (!i_req && i_cnt < 2) i_req = 1'b1;
            if (d_done) begin order.push_back(1'b1); d_req = 1'b0; d_cnt++; end
            else if (!d_req && d_cnt < 2) d_req = 1'b1;
        end
        checks++; if (order.size() != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", order.size()); end
        // Both always pending at grant time: winner alternates, fetch first.
        exp_port = 1'b0;
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] !== exp_port) begin failures++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, order[k], exp_port); end
            exp_port = ~exp_port;
        end
        i_req = 1'b0; d_req = 1'b0; man_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        prev_valid;
        logic        last_d_m;
        logic [0:0]  p;
        logic [0:0]  got_p;
        logic [31:0] last_d_read;
        int          n_done;
        do_reset();
        mem_init = 1'b1;
        @(posedge clk);
        #1 mem_init = 1'b0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
        exp_q.delete();
        auto_resp = 1'b1;
        prev_valid = 1'b0; last_d_m = 1'b1; last_d_read = 32'h0; n_done = 0;
        for (int cyc = 0; cyc < 440; cyc++) begin
            @(negedge clk);
            // new grant: who should have won, and did the bus get its request
            if (bus.m_valid && !prev_valid) begin
                if (i_req && d_req) p = last_d_m ? 1'b0 : 1'b1;
                else p = d_req ? 1'b1 : 1'b0;
                checks++;
                if (!i_req && !d_req) begin
                    failures++; $display("FAIL rnd_spurious_grant cycle=%0d got valid=1 exp no grant", cyc);
                end else if (bus.m_addr !== (p ? d_addr : i_addr) ||
                             bus.m_wmask !== (p ? d_wmask : 4'b0000) ||
                             bus.m_wdata !== (p ? d_wdata : 32'h0)) begin
                    failures++;
                    $display("FAIL rnd_grant cycle=%0d got addr=%h wmask=%h wdata=%h exp port=%0d addr=%h wmask=%h wdata=%h",
                             cyc, bus.m_addr, bus.m_wmask, bus.m_wdata, p, p ? d_addr : i_addr,
                             p ? d_wmask : 4'b0000, p ? d_wdata : 32'h0);
                end
                exp_q.push_back(p);
                last_d_m = p;
            end
            prev_valid = bus.m_valid;
            if (bus.m_valid && (i_done || d_done)) begin
                checks++; failures++;
                $display("FAIL rnd_overlap cycle=%0d got valid=1 with done exp valid=0", cyc);
            end
            if (i_done || d_done) begin
                n_done++;
                checks++;
                if (i_done && d_done) begin failures++; $display("FAIL rnd_two_done cycle=%0d got both exp one", cyc); end
                got_p = d_done;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_unexpected_done cycle=%0d got port=%0d exp none", cyc, got_p);
                end else begin
                    p = exp_q.pop_front();
                    if (got_p !== p) begin failures++; $display("FAIL rnd_done_port cycle=%0d got=%0d exp=%0d", cyc, got_p, p); end
                end
                checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd_err cycle=%0d got=1 exp=0", cyc); end
                if (i_done) begin
                    checks++;
                    if (i_rdata !== ref_mem[i_addr]) begin failures++; $display("FAIL rnd_i_rdata addr=%h got=%h exp=%h", i_addr, i_rdata, ref_mem[i_addr]); end
                    i_req = 1'b0;
                end
                if (d_done) begin
                    if (d_wmask == 4'b0000) last_d_read = ref_mem[d_addr];
                    else for (int b = 0; b < 4; b++)
                        if (d_wmask[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
                    checks++;
                    if (d_rdata !== last_d_read) begin failures++; $display("FAIL rnd_d_rdata addr=%h wmask=%h got=%h exp=%h", d_addr, d_wmask, d_rdata, last_d_read); end
                    d_req = 1'b0;
                end
            end
            if (cyc < 400) begin
                if (!i_req && !i_done && $urandom_range(0, 2) == 0) begin
                    i_req = 1'b1; i_addr = 8'($urandom_range(0, 7));
                end
                if (!d_req && !d_done && $urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_addr = 8'($urandom_range(0, 7)); d_wdata = $urandom;
                    d_wmask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                end
            end
        end
        checks++; if (exp_q.size() != 0 || i_req || d_req) begin failures++; $display("FAIL rnd_drain got pending=%0d reqs=%b%b exp 0/00", exp_q.size(), i_req, d_req); end
        checks++; if (n_done < 40) begin failures++; $display("FAIL rnd_throughput got=%0d exp>=40", n_done); end
        auto_resp = 1'b0;
        d_wmask = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        int n;
        logic seen_d;
        man_ready = 1'b0;
        d_req = 1'b1; d_addr = 8'h30; d_wmask = 4'b0000;
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== 8'h30) begin failures++; $display("FAIL rb_grant got valid=%b addr=%h exp 1/30", bus.m_valid, bus.m_addr); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_addr !== 8'h00 || bus.m_wdata !== 32'h0 || bus.m_wmask !== 4'h0 ||
            i_rdata !== 32'h0 || d_rdata !== 32'h0 || i_done !== 1'b0 || d_done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rb_reset_values got valid=%b addr=%h wdata=%h wmask=%h ir=%h dr=%h done=%b%b err=%b exp all 0",
                     bus.m_valid, bus.m_addr, bus.m_wdata, bus.m_wmask, i_rdata, d_rdata, i_done, d_done, err);
        end
        reset = 1'b1; d_req = 1'b0; man_ready = 1'b1;
        seen_d = 1'b0;
        repeat (4) begin @(negedge clk); if (d_done) seen_d = 1'b1; end
        checks++; if (seen_d !== 1'b0) begin failures++; $display("FAIL rb_no_done got d_done=1 exp=0"); end
        i_req = 1'b1; i_addr = 8'h11; d_req = 1'b1; d_addr = 8'h22; man_rdata = 32'h0000AAAA;
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== 8'h11) begin failures++; $display("FAIL rb_i_first got valid=%b addr=%h exp 1/11", bus.m_valid, bus.m_addr); end
        @(negedge clk);
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h0000AAAA) begin failures++; $display("FAIL rb_i_done got done=%b rdata=%h exp 1/0000aaaa", i_done, i_rdata); end
        i_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_done && n < 10);
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h0000AAAA) begin failures++; $display("FAIL rb_d_done got done=%b rdata=%h exp 1/0000aaaa", d_done, d_rdata); end
        d_req = 1'b0; man_ready = 1'b0;
        @(negedge clk);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        d_req = 1'b1; d_addr = 8'd3; d_wmask = 4'b0000; man_ready = 1'b1; man_rdata = 32'h00000077;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_done && n < 10);
        checks++; if (d_rdata !== 32'h00000077) begin failures++; $display("FAIL to_preload got=%h exp=00000077", d_rdata); end
        d_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_addr = 8'd6; man_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL to_grant got=%b exp=1", bus.m_valid); end
        for (int k = 1; k < TB_TIMEOUT; k++) begin
            @(negedge clk);
            checks++;
            if (bus.m_valid !== 1'b1 || d_done !== 1'b0 || err !== 1'b0) begin
                failures++; $display("FAIL to_wait cycle=%0d got valid=%b done=%b err=%b exp 1/0/0", k, bus.m_valid, d_done, err);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0 || d_done !== 1'b1 || err !== 1'b1 || d_rdata !== 32'h0) begin
            failures++; $display("FAIL to_abort got valid=%b done=%b err=%b rdata=%h exp 0/1/1/0", bus.m_valid, d_done, err, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0 || d_done !== 1'b0) begin failures++; $display("FAIL to_pulse got err=%b done=%b exp 0/0", err, d_done); end
        i_req = 1'b1; i_addr = 8'd2; man_ready = 1'b1; man_rdata = 32'h0000ABCD;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_done && n < 10);
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h0000ABCD || err !== 1'b0) begin failures++; $display("FAIL to_next got done=%b rdata=%h err=%b exp 1/0000abcd/0", i_done, i_rdata, err); end
        i_req = 1'b0; man_ready = 1'b0;
        @(negedge clk);
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_fetch();
        test_write_mask();
        test_stall();
        test_round_robin();
        test_random();
        test_reset_busy();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no end of test exp finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule
